// File: rtl/mcpu_alu_issue.sv
// Execute-stage issue register: accepts one decoded ALU instruction per
// cycle, resolves both source operands through the ALU/writeback bypass
// paths, and holds operands plus control fields stable until downstream
// accepts. Also keeps a saturating back-pressure counter.

// One operand resolver: r0, then the in-flight ALU producer, then the
// writeback producer, then the register file.
module mcpu_alu_issue_fwd #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_num,
  input  logic [31:0]      rf_data,
  input  logic             ex_valid,
  input  logic             ex_rd_we,
  input  logic [REG_W-1:0] ex_rd_num,
  input  logic [31:0]      alu_result,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd_num,
  input  logic [31:0]      wb_data,
  output logic [31:0]      src_val
);
  // Younger producer wins; r0 is checked first so an rd==0 producer never forwards.
  always_comb begin
    src_val = rf_data;
    if (src_num == '0)                                     src_val = '0;
    else if (ex_valid && ex_rd_we && ex_rd_num == src_num) src_val = alu_result;
    else if (wb_valid && wb_rd_num == src_num)             src_val = wb_data;
  end
endmodule

module mcpu_alu_issue #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [3:0]       dec_opcode,
  input  logic [2:0]       dec_compare_type,
  input  logic [1:0]       dec_shift_type,
  input  logic [5:0]       dec_shift_amount,
  input  logic [REG_W-1:0] dec_rs_num,
  input  logic [REG_W-1:0] dec_rt_num,
  input  logic [REG_W-1:0] dec_rd_num,
  input  logic             dec_rd_we,
  input  logic             dec_use_imm,
  input  logic [31:0]      dec_imm,
  input  logic [31:0]      rf_rs_data,
  input  logic [31:0]      rf_rt_data,
  input  logic [31:0]      alu_result,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd_num,
  input  logic [31:0]      wb_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [REG_W-1:0] ex_rd_num,
  output logic             ex_rd_we,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [3:0]       alu_opcode,
  output logic [2:0]       alu_compare_type,
  output logic [1:0]       alu_shift_type,
  output logic [5:0]       alu_shift_amount,
  output logic [CNT_W-1:0] perf_stall_cnt
);
  localparam int NUM_SRC = 2;  // index 0 = rs, 1 = rt

  typedef struct packed {
    logic [3:0]       opcode;
    logic [2:0]       compare_type;
    logic [1:0]       shift_type;
    logic [5:0]       shift_amount;
    logic [REG_W-1:0] rd_num;
    logic             rd_we;
    logic             use_imm;
    logic [31:0]      imm;
    logic [31:0]      op1;
    logic [31:0]      rt_val;
  } ex_req_t;

  logic [NUM_SRC-1:0][REG_W-1:0] src_num;
  logic [NUM_SRC-1:0][31:0]      src_rf;
  logic [NUM_SRC-1:0][31:0]      src_val;
  ex_req_t                       dec_req, ex_q;
  logic                          accept;
  logic [CNT_W-1:0]              stall_cnt;

  assign src_num = {dec_rt_num, dec_rs_num};
  assign src_rf  = {rf_rt_data, rf_rs_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    mcpu_alu_issue_fwd #(.REG_W(REG_W)) u_fwd (
      .src_num    (src_num[g]),
      .rf_data    (src_rf[g]),
      .ex_valid   (ex_valid),
      .ex_rd_we   (ex_q.rd_we),
      .ex_rd_num  (ex_q.rd_num),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_rd_num  (wb_rd_num),
      .wb_data    (wb_data),
      .src_val    (src_val[g])
    );
  end

  assign dec_ready = !ex_valid || ex_ready;
  assign accept    = dec_valid && dec_ready && !flush;

  // Pack the decoded fields with the resolved operands for capture.
  always_comb begin
    dec_req              = '0;
    dec_req.opcode       = dec_opcode;
    dec_req.compare_type = dec_compare_type;
    dec_req.shift_type   = dec_shift_type;
    dec_req.shift_amount = dec_shift_amount;
    dec_req.rd_num       = dec_rd_num;
    dec_req.rd_we        = dec_rd_we;
    dec_req.use_imm      = dec_use_imm;
    dec_req.imm          = dec_imm;
    dec_req.op1          = src_val[0];
    dec_req.rt_val       = src_val[1];
  end

  // Issue register: flush > accept > drain > hold.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_q     <= dec_req;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Back-pressure counter, saturating at all-ones, cleared only by reset.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n)
      stall_cnt <= '0;
    else if (ex_valid && !ex_ready && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // The immediate mux sits after the register so rt forwarding never affects it.
  assign alu_op1          = ex_q.op1;
  assign alu_op2          = ex_q.use_imm ? ex_q.imm : ex_q.rt_val;
  assign alu_opcode       = ex_q.opcode;
  assign alu_compare_type = ex_q.compare_type;
  assign alu_shift_type   = ex_q.shift_type;
  assign alu_shift_amount = ex_q.shift_amount;
  assign ex_rd_num        = ex_q.rd_num;
  assign ex_rd_we         = ex_q.rd_we;
  assign perf_stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_mcpu_alu_issue.sv
// Bench for mcpu_alu_issue: table of back-to-back instructions with an
// expected-result queue, then hand sequences for stall, flush, saturation
// and asynchronous reset.
module tb_mcpu_alu_issue;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dec_valid, dec_ready;
  logic [3:0]       dec_opcode;
  logic [2:0]       dec_compare_type;
  logic [1:0]       dec_shift_type;
  logic [5:0]       dec_shift_amount;
  logic [REG_W-1:0] dec_rs_num, dec_rt_num, dec_rd_num;
  logic             dec_rd_we, dec_use_imm;
  logic [31:0]      dec_imm, rf_rs_data, rf_rt_data, alu_result;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd_num;
  logic [31:0]      wb_data;
  logic             flush, ex_ready, ex_valid;
  logic [REG_W-1:0] ex_rd_num;
  logic             ex_rd_we;
  logic [31:0]      alu_op1, alu_op2;
  logic [3:0]       alu_opcode;
  logic [2:0]       alu_compare_type;
  logic [1:0]       alu_shift_type;
  logic [5:0]       alu_shift_amount;
  logic [CNT_W-1:0] perf_stall_cnt;

  always #5 clk = ~clk;

  mcpu_alu_issue #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_compare_type(dec_compare_type), .dec_shift_type(dec_shift_type),
    .dec_shift_amount(dec_shift_amount), .dec_rs_num(dec_rs_num),
    .dec_rt_num(dec_rt_num), .dec_rd_num(dec_rd_num), .dec_rd_we(dec_rd_we),
    .dec_use_imm(dec_use_imm), .dec_imm(dec_imm), .rf_rs_data(rf_rs_data),
    .rf_rt_data(rf_rt_data), .alu_result(alu_result), .wb_valid(wb_valid),
    .wb_rd_num(wb_rd_num), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_rd_num(ex_rd_num), .ex_rd_we(ex_rd_we),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_compare_type(alu_compare_type), .alu_shift_type(alu_shift_type),
    .alu_shift_amount(alu_shift_amount), .perf_stall_cnt(perf_stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic        we, use_imm;
    logic [31:0] imm, rf_rs, rf_rt, alu_res;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  opcode;
    logic [31:0] exp1, exp2;
  } vec_t;

  typedef struct {
    logic [31:0] op1, op2;
    logic [3:0]  opc;
    logic [2:0]  cmp;
    logic [1:0]  sht;
    logic [5:0]  sha;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  localparam int NV = 10;
  vec_t vt [NV];
  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [31:0] rfs,
                           input logic [4:0] rt, input logic [31:0] rft,
                           input logic [4:0] rd, input logic we, input logic [3:0] opc);
    dec_rs_num = rs; rf_rs_data = rfs; dec_rt_num = rt; rf_rt_data = rft;
    dec_rd_num = rd; dec_rd_we = we; dec_opcode = opc;
    dec_use_imm = 1'b0; dec_imm = '0;
    dec_compare_type = '0; dec_shift_type = '0; dec_shift_amount = '0;
  endtask

  // Pop the oldest expectation and compare it with the held outputs.
  task automatic check_head();
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("ex_valid", 32'(ex_valid), 32'd1);
    chk("alu_op1", alu_op1, e.op1);
    chk("alu_op2", alu_op2, e.op2);
    chk("alu_opcode", 32'(alu_opcode), 32'(e.opc));
    chk("alu_cmp", 32'(alu_compare_type), 32'(e.cmp));
    chk("alu_shift", 32'({alu_shift_type, alu_shift_amount}), 32'({e.sht, e.sha}));
    chk("ex_rd", 32'({ex_rd_we, ex_rd_num}), 32'({e.we, e.rd}));
  endtask

  initial begin
    exp_t e;
    // rs rt rd we imm? imm rf_rs rf_rt alu_res wb_v wb_rd wb_data opc exp1 exp2
    vt[0] = '{5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h0, 32'h5, 32'h7, 32'h99, 1'b0, 5'd0, 32'h0, 4'h0, 32'h5, 32'h7};
    vt[1] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0, 32'h11, 32'h22, 32'h12, 1'b0, 5'd0, 32'h0, 4'h1, 32'h11, 32'h22};
    vt[2] = '{5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 32'h0, 32'hDEAD, 32'hDEAD, 32'h10, 1'b0, 5'd0, 32'h0, 4'h1, 32'h10, 32'h10};
    vt[3] = '{5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, 32'h77, 32'h77, 32'h31, 1'b1, 5'd0, 32'h55, 4'h2, 32'h0, 32'h0};
    vt[4] = '{5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 32'h0, 32'h66, 32'h66, 32'hAA, 1'b1, 5'd6, 32'hBB, 4'h3, 32'hAA, 32'hAA};
    vt[5] = '{5'd6, 5'd6, 5'd8, 1'b1, 1'b0, 32'h0, 32'h66, 32'h66, 32'hAA, 1'b1, 5'd6, 32'hBB, 4'h4, 32'hBB, 32'hBB};
    vt[6] = '{5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 32'hFFFF_FF80, 32'h88, 32'h88, 32'h1234, 1'b1, 5'd8, 32'h5678, 4'h5, 32'h1234, 32'hFFFF_FF80};
    vt[7] = '{5'd10, 5'd11, 5'd0, 1'b1, 1'b0, 32'h0, 32'hA5A5_0000, 32'h0000_5A5A, 32'h4321, 1'b1, 5'd12, 32'hC0DE, 4'h6, 32'hA5A5_0000, 32'h0000_5A5A};
    vt[8] = '{5'd0, 5'd13, 5'd14, 1'b1, 1'b0, 32'h0, 32'h0D, 32'h13, 32'hCC, 1'b0, 5'd0, 32'h0, 4'hF, 32'h0, 32'h13};
    vt[9] = '{5'd14, 5'd15, 5'd16, 1'b1, 1'b0, 32'h0, 32'h0E, 32'h0F, 32'hEE, 1'b1, 5'd15, 32'hF5, 4'h7, 32'hEE, 32'hF5};

    rst_n = 1'b0; dec_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    alu_result = '0; wb_valid = 1'b0; wb_rd_num = '0; wb_data = '0;
    set_instr(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst dec_ready", 32'(dec_ready), 32'd1);
    chk("rst op1", alu_op1, 32'd0);
    chk("rst op2", alu_op2, 32'd0);
    chk("rst fields", 32'({alu_opcode, alu_compare_type, alu_shift_type, alu_shift_amount, ex_rd_we, ex_rd_num}), 32'd0);
    chk("rst perf", 32'(perf_stall_cnt), 32'd0);
    rst_n = 1'b1;

    // Back-to-back issue with ex_ready high: each entry is held one cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check_head();
      set_instr(vt[i].rs, vt[i].rf_rs, vt[i].rt, vt[i].rf_rt, vt[i].rd, vt[i].we, vt[i].opcode);
      dec_use_imm = vt[i].use_imm; dec_imm = vt[i].imm;
      dec_compare_type = 3'(i); dec_shift_type = 2'(i + 1); dec_shift_amount = 6'(i * 5 + 1);
      alu_result = vt[i].alu_res; wb_valid = vt[i].wb_v;
      wb_rd_num = vt[i].wb_rd; wb_data = vt[i].wb_data;
      dec_valid = 1'b1;
      e.op1 = vt[i].exp1; e.op2 = vt[i].exp2; e.opc = vt[i].opcode;
      e.cmp = 3'(i); e.sht = 2'(i + 1); e.sha = 6'(i * 5 + 1);
      e.rd = vt[i].rd; e.we = vt[i].we;
      sbq.push_back(e);
    end
    @(negedge clk);
    check_head();
    chk("queue drained", 32'(sbq.size()), 32'd0);

    // Stall: A captured, then ex_ready low for 3 cycles with B waiting.
    wb_valid = 1'b0; alu_result = 32'h4242;
    set_instr(5'd20, 32'h20, 5'd21, 32'h21, 5'd22, 1'b1, 4'h9);
    @(negedge clk);
    ex_ready = 1'b0;
    set_instr(5'd22, 32'hDEAD, 5'd0, 32'h5, 5'd23, 1'b1, 4'hA);
    #1 chk("stall dec_ready", 32'(dec_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("stall op1 held", alu_op1, 32'h20);
    chk("stall op2 held", alu_op2, 32'h21);
    chk("stall opcode held", 32'(alu_opcode), 32'h9);
    chk("stall ex_valid", 32'(ex_valid), 32'd1);
    chk("stall cnt 3", 32'(perf_stall_cnt), 32'd3);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("B captured fwd", alu_op1, 32'h4242);
    chk("B op2 r0", alu_op2, 32'h0);
    chk("B rd", 32'(ex_rd_num), 32'd23);
    chk("cnt after release", 32'(perf_stall_cnt), 32'd3);

    // Flush with a valid decode: nothing held next cycle, no stall counted.
    ex_ready = 1'b0; flush = 1'b1;
    set_instr(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b1, 4'hB);
    @(negedge clk);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush cnt", 32'(perf_stall_cnt), 32'd3);

    // Long stall: counter saturates at 2^CNT_W-1.
    flush = 1'b0; ex_ready = 1'b1;
    set_instr(5'd24, 32'h24, 5'd25, 32'h25, 5'd26, 1'b1, 4'hC);
    @(negedge clk);
    chk("D ex_valid", 32'(ex_valid), 32'd1);
    chk("D op1", alu_op1, 32'h24);
    dec_valid = 1'b0; ex_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("cnt saturated", 32'(perf_stall_cnt), 32'd15);
    chk("D op2 held", alu_op2, 32'h25);

    // Reset mid-stall, checked before the next clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("async rst ex_valid", 32'(ex_valid), 32'd0);
    chk("async rst cnt", 32'(perf_stall_cnt), 32'd0);
    chk("async rst op1", alu_op1, 32'd0);
    chk("async rst dec_ready", 32'(dec_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcpu_alu_issue.md
# mcpu_alu_issue

Execute-stage issue register sitting directly upstream of the combinational ALU. It accepts one decoded ALU instruction per cycle from decode over a valid/ready handshake and resolves both source operands. Operands come from the register-file read data or from two bypass paths: the in-flight ALU result and the writeback result. It holds the resolved operands and control fields stable as ALU inputs until the downstream stage accepts. It also keeps a saturating back-pressure counter for performance monitoring.

## Interface
- `REG_W`, default 5: register index width; register 0 always reads as zero.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clkrst_core_clk` in 1: core clock.
- `clkrst_core_rst_n` in 1: reset, asynchronous, active-low.
- `dec_valid` in 1: decode presents an instruction.
- `dec_ready` out 1: issue register can accept.
- `dec_opcode` in 4: ALU opcode.
- `dec_compare_type` in 3: ALU compare type.
- `dec_shift_type` in 2: ALU shift type.
- `dec_shift_amount` in 6: ALU shift amount.
- `dec_rs_num` in REG_W: op1 source register.
- `dec_rt_num` in REG_W: op2 source register.
- `dec_rd_num` in REG_W: destination register.
- `dec_rd_we` in 1: instruction writes rd.
- `dec_use_imm` in 1: op2 comes from the immediate, not rt.
- `dec_imm` in 32: immediate.
- `rf_rs_data` in 32: register-file read of rs, same cycle as dec_valid.
- `rf_rt_data` in 32: register-file read of rt, same cycle as dec_valid.
- `alu_result` in 32: combinational ALU output for the currently held instruction.
- `wb_valid` in 1: writeback stage is writing this cycle.
- `wb_rd_num` in REG_W: writeback destination.
- `wb_data` in 32: writeback value.
- `flush` in 1: squash the held instruction and drop any same-cycle capture.
- `ex_ready` in 1: downstream accepts the held instruction.
- `ex_valid` out 1: held instruction valid.
- `ex_rd_num` out REG_W: held destination.
- `ex_rd_we` out 1: held write enable.
- `alu_op1` out 32: ALU op1.
- `alu_op2` out 32: ALU op2.
- `alu_opcode` out 4: registered ALU field.
- `alu_compare_type` out 3: registered ALU field.
- `alu_shift_type` out 2: registered ALU field.
- `alu_shift_amount` out 6: registered ALU field.
- `perf_stall_cnt` out CNT_W: cycles with ex_valid & !ex_ready, saturating.

## Operation
- Handshake: dec_ready = !ex_valid | ex_ready (combinational). Accept = dec_valid & dec_ready & !flush.
- Register update priority:
  - flush: ex_valid <= 0.
  - else accept: capture all fields, ex_valid <= 1.
  - else ex_ready: ex_valid <= 0.
  - else hold all state.
- Operand resolution applies independently to rs (into alu_op1) and rt; first match wins:
  - Source register is 0: value 0.
  - ex_valid & ex_rd_we & ex_rd_num == src: alu_result. This is the younger producer, and it is necessarily leaving, since accept implies ex_ready.
  - wb_valid & wb_rd_num == src: wb_data.
  - Otherwise rf data.
- alu_op2 = registered use_imm ? registered imm : resolved rt value. The multiplexer follows the register.
- rs == rt with a match: both operands receive the same forwarded value.
- Producer with rd == 0: never forwarded.
- ALU-invalid opcodes are still forwarded. The downstream exception logic must assert flush.
- perf_stall_cnt:
  - Increments each cycle ex_valid & !ex_ready & !flush.
  - Holds at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the clock tree):
  - ex_valid, ex_rd_we, ex_rd_num, all alu_* outputs and perf_stall_cnt are 0.
  - dec_ready is 1.
- Latency: accept at edge N, so ex_valid and operands are present from N through the edge where ex_ready = 1.
- Throughput: one instruction per cycle with ex_ready held high. Back-to-back dependent instructions incur no bubble.
- Held outputs are stable while ex_valid & !ex_ready.
- flush together with dec_valid: the instruction is dropped, and the decoder is responsible for reissuing.
- flush together with ex_ready: ex_valid clears.
- Reset asserted mid-stall: outputs clear immediately without waiting for a clock.

## Test plan
- Reset, then dec_valid with rs = 3 and rf_rs_data = 5, rt = 4 and rf_rt_data = 7, opcode 0000, ex_ready = 1 -> next cycle ex_valid = 1, alu_op1 = 5, alu_op2 = 7, alu_opcode = 0.
- Back-to-back: r3 = r1 + r2 (held, alu_result = 0x10), then r4 = r3 + r3 with rf_rs_data = rf_rt_data = 0xDEAD -> alu_op1 = alu_op2 = 0x10.
- Priority: held rd = 6 with alu_result = 0xAA, wb_valid with wb_rd_num = 6 and wb_data = 0xBB; next instruction reads r6 -> 0xAA. Same case with the held instruction having rd_we = 0 -> 0xBB. Source r0 with wb_rd_num = 0 -> 0.
- Stall: ex_ready low for 3 cycles with dec_valid high -> dec_ready = 0, outputs unchanged, perf_stall_cnt = 3. ex_ready high -> the new instruction is captured.
- Immediate: dec_use_imm = 1 with imm = 0xFFFF_FF80 -> alu_op2 = 0xFFFF_FF80, regardless of rt forwarding matches.
- Flush with dec_valid asserted -> ex_valid = 0 next cycle. Reset asserted mid-stall -> ex_valid = 0 and perf_stall_cnt = 0 with no clock edge.
